// File: rtl/mssd_param_pkg.sv
// ============================================================================
// Package : mssd_pkg
// Purpose : Shared types and helpers for the parametrised serial message
//           demultiplexer (mssd_param and its control unit).
// Contents: state_t   - frame-decoder FSM states
//           cnt_width - width of the per-field bit counter
// ============================================================================
`default_nettype none

package mssd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4,
    END  = 3'd5
  } state_t;

  // One counter is reused for the address, length and payload fields. The
  // payload never exceeds 2^LEN_W-1 bits, so the wider of the two header
  // fields is always enough.
  function automatic int cnt_width(input int addr_w, input int len_w);
    return (addr_w > len_w) ? addr_w : len_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mssd_param_cu.sv
// ============================================================================
// Module  : mssd_param_cu
// Purpose : Control unit of mssd_param: frame FSM, per-field bit counter and
//           error flagging.
// Ports   : clk, rst (async, active-low), serIn - serial input
//           addr_nx  - address register value after shifting in serIn
//           len_nx   - length register value after shifting in serIn
//           len_q    - latched payload length
//           par_acc  - XOR of the payload bits received so far
//           state    - current FSM state (drives the datapath)
//           busy/done/error - status outputs
// ============================================================================
`default_nettype none

module mssd_param_cu
  import mssd_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int ADDR_W    = 2,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  input  logic [ADDR_W-1:0] addr_nx,
  input  logic [LEN_W-1:0]  len_nx,
  input  logic [LEN_W-1:0]  len_q,
  input  logic              par_acc,
  output state_t            state,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = cnt_width(ADDR_W, LEN_W);

  state_t           state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err_flag, err_flag_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      err_flag <= err_flag_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 1'b1;
    err_flag_nx = err_flag;
    case (state)
      IDLE: begin
        cnt_nx      = '0;
        err_flag_nx = 1'b0;
        if (!serIn) state_nx = ADDR;
      end
      ADDR: begin
        if (cnt == CNT_W'(ADDR_W - 1)) begin
          state_nx = LEN;
          cnt_nx   = '0;
          // Checked on the full address; the payload is still consumed.
          if ({1'b0, addr_nx} >= (ADDR_W + 1)'(N_PORTS)) err_flag_nx = 1'b1;
        end
      end
      LEN: begin
        if (cnt == CNT_W'(LEN_W - 1)) begin
          cnt_nx = '0;
          if (len_nx == '0) begin
            err_flag_nx = 1'b1;
            state_nx    = END;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        // len_q >= 1 here, so the decrement cannot underflow.
        if (cnt == CNT_W'(len_q - 1'b1)) begin
          cnt_nx   = '0;
          state_nx = (PARITY_EN != 0) ? PAR : END;
        end
      end
      PAR: begin
        cnt_nx   = '0;
        state_nx = END;
        if (serIn != par_acc) err_flag_nx = 1'b1;
      end
      END: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == END);
  assign error = (state == END) && err_flag;

endmodule

`default_nettype wire

// File: rtl/mssd_param.sv
// ============================================================================
// Module  : mssd_param
// Purpose : Parametrised serial-to-port message demultiplexer. Decodes
//           frames {start 0, addr, len, payload, [even parity]} (MSB first)
//           and routes each payload bit to port p[addr] one cycle later.
// Ports   : clk, rst (async, active-low), serIn (idle high)
//           p        - routed payload bit, one-hot on port d
//           d        - address of the current message while outValid=1
//           outValid - one cycle per delivered payload bit
//           error    - pulse in END on parity/zero-length/bad-address
//           done     - pulse in END of every frame
//           busy     - FSM not in IDLE
// ============================================================================
`default_nettype none

module mssd_param
  import mssd_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serIn,
  output logic [N_PORTS-1:0]         p,
  output logic [$clog2(N_PORTS)-1:0] d,
  output logic                       outValid,
  output logic                       error,
  output logic                       done,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(N_PORTS);

  state_t            state;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [LEN_W-1:0]  len_q, len_nx;
  logic              par_q;
  logic              addr_ok;

  assign addr_nx = (addr_q << 1) | ADDR_W'(serIn);
  assign len_nx  = (len_q << 1) | LEN_W'(serIn);
  assign addr_ok = ({1'b0, addr_q} < (ADDR_W + 1)'(N_PORTS));

  mssd_param_cu #(
    .N_PORTS   (N_PORTS),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .PARITY_EN (PARITY_EN)
  ) u_cu (
    .clk     (clk),
    .rst     (rst),
    .serIn   (serIn),
    .addr_nx (addr_nx),
    .len_nx  (len_nx),
    .len_q   (len_q),
    .par_acc (par_q),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      par_q    <= 1'b0;
      p        <= '0;
      d        <= '0;
      outValid <= 1'b0;
    end else begin
      if (state == ADDR) addr_q <= addr_nx;
      if (state == LEN) begin
        len_q <= len_nx;
        par_q <= 1'b0;
      end
      if (state == DATA) par_q <= par_q ^ serIn;

      // Out-of-range addresses are consumed silently; the error is
      // reported in END by the control unit.
      if (state == DATA && addr_ok) begin
        p        <= N_PORTS'(serIn) << addr_q;
        d        <= addr_q;
        outValid <= 1'b1;
      end else begin
        p        <= '0;
        d        <= '0;
        outValid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mssd_param.md
Name: mssd_param

Overview:
- Parametrised serial-to-port message demultiplexer; next generation of the fixed 4-port MSSD.
- Receives framed messages on one serial line and routes the payload bits to one of N_PORTS outputs.
- Generalised port count and length-field width; adds optional even parity, zero-length and bad-address error detection, and busy/done status.
- Sits between the serial receive pin logic and per-port consumers.

Parameters:
- N_PORTS, 4, number of output ports (2..16).
- ADDR_W, $clog2(N_PORTS), localparam; width of the address field and of d.
- LEN_W, 4, width of the payload-length field; maximum payload is 2^LEN_W-1 bits.
- PARITY_EN, 1, 1 = an even-parity bit follows the payload; 0 = no parity bit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- serIn  in  1  serial line, sampled every clk; idle level is 1.
- p  out  N_PORTS  registered routed payload bit; only bit d may be nonzero, and only while outValid=1.
- d  out  ADDR_W  address of the current message; valid while outValid=1, 0 otherwise.
- outValid  out  1  high one cycle per delivered payload bit.
- error  out  1  one-cycle pulse: parity mismatch, zero length, or address >= N_PORTS.
- done  out  1  one-cycle pulse at the end of every accepted frame, good or bad.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous) clears every output to 0 (p, d, outValid, error, done, busy) and returns the FSM to IDLE. Reset mid-frame discards the partial frame; no error or done is produced.
- Frame, MSB-first for every field: start bit 0, then ADDR_W address bits, then LEN_W length bits L, then L payload bits, then the parity bit (only if PARITY_EN=1).
- FSM states: IDLE, ADDR, LEN, DATA, PAR, END.
  - IDLE: serIn=0 -> ADDR with cnt=0.
  - ADDR: shift serIn into addr; after ADDR_W bits -> LEN.
  - LEN: shift into len; after LEN_W bits, L=0 -> END with error flagged, else DATA.
  - DATA: each cycle register serIn to p[addr] and set outValid=1 in the next cycle, accumulating parity XOR. After L bits, go to PAR if PARITY_EN=1, else END.
  - PAR: compare serIn with the accumulated XOR; mismatch flags error -> END.
  - END: a single cycle that pulses done, plus error if flagged, then goes to IDLE.
- Latency: each payload bit appears on p exactly 1 cycle after it is sampled.
- Frame length in cycles (start bit through END, inclusive): 1+ADDR_W+LEN_W+L+PARITY_EN+1.
- A new start bit is accepted in the cycle after END. No idle gap is required beyond that cycle.
- Address >= N_PORTS: the payload is consumed but not driven. p stays 0 and outValid stays 0; error pulses in END.
- The bit counter is max(ADDR_W,LEN_W) bits wide, is reused per field, and clears on each state change. No wrap is possible because L <= 2^LEN_W-1.
- serIn=1 in IDLE is ignored.
- error and done may be high together in END; done is always high in END.

Decomposition:
- Package mssd_pkg holds:
  - state enum (IDLE, ADDR, LEN, DATA, PAR, END);
  - localparam helper for the counter width.
- One sub-module, mssd_param_cu, contains the FSM, counter control and error flagging.
- The shift registers, parity accumulator and output registers stay in the top-level datapath, mirroring the existing CU/DP split.

Test Plan:
- Defaults, frame 0,10,0011,1,0,1,par 0 -> p[2]=1,0,1 on three consecutive cycles with d=2 and outValid=1; done pulses 1 cycle after the parity bit; error=0; other p bits stay 0.
- Same frame with parity bit 1 -> identical payload output; error and done pulse together in END.
- Frame 0,01,0000 -> no outValid; error and done pulse together the cycle after the last length bit; busy drops to 0 the next cycle.
- N_PORTS=3, frame 0,11,0010,1,1,0 -> outValid stays 0 throughout and p stays 0; error pulses in END.
- Back-to-back: second start bit driven the cycle after END, frame 0,00,0001,1,1 -> p[0]=1 once; both frames complete with no error.
- rst=0 asserted during the DATA state of a 15-bit frame -> all outputs 0 immediately (async); after release, serIn=1 holds IDLE and the next valid frame decodes correctly.
- PARITY_EN=0, frame 0,11,0010,0,1 -> p[3]=0, then 1; done follows the last data bit by 1 cycle.
